backing_memory: RTL and testbench

- Parametrised slow backing store behind the data cache.
- Serves one request at a time with a fixed, programmable access latency.
- On reads, returns both the addressed word (pipeline path) and the full block (cache refill path); on writes, performs a write-through.
- Replaces a hard-wired 2-word × 64-block, 20-cycle memory with a valid/ready request interface and a single-cycle completion pulse.

---
 rtl/backing_memory_if.sv | 42 ++++
 rtl/backing_memory.sv | 135 +++++++++++++
 tb/tb_backing_memory.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/backing_memory_if.sv
// rtl/backing_memory_if.sv - request/response bus of the backing memory
// Ports (signals grouped by this interface):
//   req_valid/req_ready  request handshake, req_write selects write
//   req_addr/req_wdata   byte address and write data
//   req_wstrb            byte strobes (only with BACKING_MEM_WSTRB_EN)
//   resp_valid           one-cycle completion pulse
//   resp_word/resp_block addressed word and full block of the last read
//   busy                 request outstanding
// Modports: master drives requests, slave is the memory.
interface backing_memory_if #(
  parameter int ADDR_W          = 32,
  parameter int WORDS_PER_BLOCK = 2
);
  logic                         req_valid;
  logic                         req_ready;
  logic                         req_write;
  logic [ADDR_W-1:0]            req_addr;
  logic [31:0]                  req_wdata;
`ifdef BACKING_MEM_WSTRB_EN
  logic [3:0]                   req_wstrb;
`endif
  logic                         resp_valid;
  logic [31:0]                  resp_word;
  logic [32*WORDS_PER_BLOCK-1:0] resp_block;
  logic                         busy;

  modport master (
`ifdef BACKING_MEM_WSTRB_EN
    output req_wstrb,
`endif
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_word, resp_block, busy
  );

  modport slave (
`ifdef BACKING_MEM_WSTRB_EN
    input  req_wstrb,
`endif
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_word, resp_block, busy
  );
endinterface

// File: rtl/backing_memory.sv
// rtl/backing_memory.sv - fixed-latency backing store behind the data cache
// Optional feature macro: BACKING_MEM_WSTRB_EN (per-byte write strobes).
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    backing_memory_if.slave request/response bus
// One request is served at a time; completion arrives LATENCY edges after
// acceptance. Reads return the word and the whole block, writes go through.
module backing_memory #(
  parameter int ADDR_W          = 32,
  parameter int WORDS_PER_BLOCK = 2,
  parameter int NUM_BLOCKS      = 64,
  parameter int LATENCY         = 20
) (
  input  logic              clk,
  input  logic              reset,
  backing_memory_if.slave   bus
);
  localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int BLK_W = 32 * WORDS_PER_BLOCK;
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY);

  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, next_state;

  logic [CNT_W-1:0] count;
  logic             lat_write;
  logic [OFF_W-1:0] lat_off;
  logic [IDX_W-1:0] lat_idx;
  logic [31:0]      lat_wdata;
  logic [31:0]      new_word;
  logic             accept, complete, ready_c, busy_c;
  logic             resp_valid_q;
  logic [31:0]      resp_word_q;
  logic [BLK_W-1:0] resp_block_q;
  logic             unused_addr;

  // 2-state storage so simulation starts from all zeros; never reset.
  bit   [BLK_W-1:0] mem [NUM_BLOCKS];

  // Byte offset and upper address bits are deliberately dropped (aliasing).
  assign unused_addr = ^bus.req_addr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    ready_c    = 1'b0;
    busy_c     = 1'b0;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid) begin
          accept     = 1'b1;
          next_state = WAIT;
        end
      end
      WAIT: begin
        busy_c = 1'b1;
        if (count == LAST) begin
          complete   = 1'b1;
          next_state = IDLE;
        end
      end
    endcase
  end

`ifdef BACKING_MEM_WSTRB_EN
  logic [3:0] lat_wstrb;

  // Merge the strobed bytes into the current contents of the target word.
  always_comb begin
    new_word = mem[lat_idx][32*lat_off +: 32];
    for (int b = 0; b < 4; b++) begin
      if (lat_wstrb[b]) new_word[8*b +: 8] = lat_wdata[8*b +: 8];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       lat_wstrb <= 4'h0;
    else if (accept) lat_wstrb <= bus.req_wstrb;
  end
`else
  assign new_word = lat_wdata;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      lat_write    <= 1'b0;
      lat_off      <= '0;
      lat_idx      <= '0;
      lat_wdata    <= '0;
      resp_valid_q <= 1'b0;
      resp_word_q  <= '0;
      resp_block_q <= '0;
    end else begin
      resp_valid_q <= complete;
      if (accept) begin
        count     <= CNT_W'(1);
        lat_write <= bus.req_write;
        lat_off   <= bus.req_addr[2 +: OFF_W];
        lat_idx   <= bus.req_addr[2+OFF_W +: IDX_W];
        lat_wdata <= bus.req_wdata;
      end else if (complete) begin
        count <= '0;
        if (!lat_write) begin
          resp_block_q <= mem[lat_idx];
          resp_word_q  <= mem[lat_idx][32*lat_off +: 32];
        end
      end else if (state == WAIT) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  // Reset forces state to IDLE asynchronously, so complete drops and an
  // aborted write never reaches the array.
  always_ff @(posedge clk) begin
    if (complete && lat_write) mem[lat_idx][32*lat_off +: 32] <= new_word;
  end

  assign bus.req_ready  = ready_c;
  assign bus.busy       = busy_c;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_word  = resp_word_q;
  assign bus.resp_block = resp_block_q;
endmodule

// File: tb/tb_backing_memory.sv
// tb/tb_backing_memory.sv - directed self-checking bench for backing_memory
module tb_backing_memory;
  logic clk;
  logic reset;
  int   vectors;
  int   errs;

  backing_memory_if #(.ADDR_W(32), .WORDS_PER_BLOCK(2)) m0 ();
  backing_memory_if #(.ADDR_W(32), .WORDS_PER_BLOCK(2)) m1 ();

  backing_memory #(.ADDR_W(32), .WORDS_PER_BLOCK(2), .NUM_BLOCKS(64), .LATENCY(20))
    dut0 (.clk(clk), .reset(reset), .bus(m0));
  backing_memory #(.ADDR_W(32), .WORDS_PER_BLOCK(2), .NUM_BLOCKS(64), .LATENCY(1))
    dut1 (.clk(clk), .reset(reset), .bus(m1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request on dut0 from IDLE, scramble the request lines during
  // WAIT and return at the negedge where resp_valid is seen.
  task automatic issue0(input logic w, input logic [31:0] a, input logic [31:0] d);
    int lat;
    bit busy_ok;
    @(negedge clk);
    m0.req_valid = 1'b1;
    m0.req_write = w;
    m0.req_addr  = a;
    m0.req_wdata = d;
    chk("ready_at_issue", m0.req_ready, 1);
    @(negedge clk);
    m0.req_valid = 1'b0;
    m0.req_write = 1'($urandom);
    m0.req_addr  = $urandom;
    m0.req_wdata = $urandom;
    lat = 0;
    busy_ok = 1'b1;
    while (!m0.resp_valid && lat < 100) begin
      if (!m0.busy || m0.req_ready) busy_ok = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, 20);
    chk("busy_in_wait", busy_ok, 1);
    chk("ready_in_resp", m0.req_ready, 1);
    chk("busy_in_resp", m0.busy, 0);
  endtask

  initial begin
    int  n;
    bit  seen;
    vectors = 0;
    errs    = 0;
    reset   = 1'b1;
    m0.req_valid = 1'b0; m0.req_write = 1'b0; m0.req_addr = '0; m0.req_wdata = '0;
    m1.req_valid = 1'b0; m1.req_write = 1'b0; m1.req_addr = '0; m1.req_wdata = '0;
`ifdef BACKING_MEM_WSTRB_EN
    m0.req_wstrb = 4'hF;
    m1.req_wstrb = 4'hF;
`endif
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_ready", m0.req_ready, 1);
    chk("rst_busy", m0.busy, 0);
    chk("rst_resp_valid", m0.resp_valid, 0);
    chk("rst_resp_word", m0.resp_word, 0);
    chk("rst_resp_block", m0.resp_block, 0);

    // Read of zeroed memory, pulse width one cycle
    issue0(1'b0, 32'h0, 32'h0);
    chk("rd0_word", m0.resp_word, 0);
    chk("rd0_block", m0.resp_block, 0);
    @(negedge clk);
    chk("rd0_pulse_end", m0.resp_valid, 0);

    // Write-through then read back both words of block 0
    issue0(1'b1, 32'h4, 32'hDEADBEEF);
    chk("wr_holds_word", m0.resp_word, 0);
    issue0(1'b0, 32'h0, 32'h0);
    chk("rd00_block", m0.resp_block, 64'hDEADBEEF_00000000);
    chk("rd00_word", m0.resp_word, 0);
    issue0(1'b0, 32'h4, 32'h0);
    chk("rd04_word", m0.resp_word, 32'hDEADBEEF);
    issue0(1'b1, 32'hC, 32'h0BADF00D);
    chk("wr_hold_word", m0.resp_word, 32'hDEADBEEF);
    chk("wr_hold_block", m0.resp_block, 64'hDEADBEEF_00000000);

    // req_valid held high: back-to-back, address change mid-WAIT ignored
    @(negedge clk);
    m0.req_valid = 1'b1; m0.req_write = 1'b0; m0.req_addr = 32'h0;
    @(negedge clk);
    chk("b2b_ready_wait", m0.req_ready, 0);
    m0.req_addr = 32'h4;
    n = 0;
    while (!m0.resp_valid && n < 100) begin @(negedge clk); n++; end
    chk("b2b_lat1", n, 20);
    chk("b2b_word1", m0.resp_word, 0);
    chk("b2b_ready_resp", m0.req_ready, 1);
    @(negedge clk);
    m0.req_valid = 1'b0;
    chk("b2b_accepted", m0.busy, 1);
    n = 1;
    while (!m0.resp_valid && n < 100) begin @(negedge clk); n++; end
    chk("b2b_spacing", n, 21);
    chk("b2b_word2", m0.resp_word, 32'hDEADBEEF);

    // Reset in the middle of a write to 0x08
    @(negedge clk);
    m0.req_valid = 1'b1; m0.req_write = 1'b1; m0.req_addr = 32'h8; m0.req_wdata = 32'h12345678;
    @(negedge clk);
    m0.req_valid = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("arst_busy", m0.busy, 0);
    chk("arst_resp_word", m0.resp_word, 0);
    chk("arst_resp_block", m0.resp_block, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_ready", m0.req_ready, 1);
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (m0.resp_valid) seen = 1'b1;
    end
    chk("arst_no_resp", seen, 0);
    issue0(1'b0, 32'h8, 32'h0);
    chk("arst_rd08_word", m0.resp_word, 0);
    chk("arst_rd08_block", m0.resp_block, 64'h0BADF00D_00000000);
    issue0(1'b0, 32'h4, 32'h0);
    chk("arst_mem_kept", m0.resp_word, 32'hDEADBEEF);

    // Aliasing: 0x200 wraps onto 0x0
    issue0(1'b1, 32'h200, 32'hA5A5A5A5);
    issue0(1'b0, 32'h0, 32'h0);
    chk("alias_word", m0.resp_word, 32'hA5A5A5A5);
    chk("alias_block", m0.resp_block, 64'hDEADBEEF_A5A5A5A5);

`ifdef BACKING_MEM_WSTRB_EN
    // Byte strobes
    m0.req_wstrb = 4'hF;
    issue0(1'b1, 32'h10, 32'h11223344);
    m0.req_wstrb = 4'b0101;
    issue0(1'b1, 32'h10, 32'hAABBCCDD);
    m0.req_wstrb = 4'b0000;
    issue0(1'b1, 32'h10, 32'hFFFFFFFF);
    m0.req_wstrb = 4'hF;
    issue0(1'b0, 32'h10, 32'h0);
    chk("wstrb_word", m0.resp_word, 32'h11BB33DD);
`endif

    // LATENCY=1 instance: completion one edge after acceptance
    @(negedge clk);
    m1.req_valid = 1'b1; m1.req_write = 1'b1; m1.req_addr = 32'h18; m1.req_wdata = 32'hCAFEF00D;
    @(negedge clk);
    m1.req_valid = 1'b0;
    chk("l1_wr_busy", m1.busy, 1);
    chk("l1_wr_noresp", m1.resp_valid, 0);
    @(negedge clk);
    chk("l1_wr_resp", m1.resp_valid, 1);
    chk("l1_wr_idle", m1.busy, 0);
    m1.req_valid = 1'b1; m1.req_write = 1'b0; m1.req_addr = 32'h18;
    @(negedge clk);
    m1.req_valid = 1'b0;
    chk("l1_rd_noresp", m1.resp_valid, 0);
    @(negedge clk);
    chk("l1_rd_resp", m1.resp_valid, 1);
    chk("l1_rd_word", m1.resp_word, 32'hCAFEF00D);
    chk("l1_rd_block", m1.resp_block, 64'h00000000_CAFEF00D);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
